// File: rtl/dec_bcd_pkg.sv
// Shared constants, types and helpers for the decimal-request arbiter.
package dec_bcd_pkg;

   localparam int unsigned NUM_DEC  = 10;
   localparam int unsigned BCD_W    = 4;
   localparam logic [3:0]  LAST_IDX = 4'd9;

   typedef logic [NUM_DEC-1:0] dec_vec_t;

   // Digit indices above 9 never reach the stream; map them to 0.
   function automatic logic [BCD_W-1:0] idx_to_bcd(input logic [3:0] idx);
      return (idx > LAST_IDX) ? 4'd0 : idx;
   endfunction

endpackage

// File: rtl/dec_rr_pick.sv
// Combinational round-robin finder: first set bit of req scanning ptr+1, ptr+2, ... with 9 wrapping to 0.
module dec_rr_pick
   import dec_bcd_pkg::*;
(
   input  dec_vec_t   req,
   input  logic [3:0] ptr,
   output logic       found,
   output logic [3:0] idx
);

   logic [4:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = 4'd0;
      pos   = 5'd0;
      for (int k = 1; k <= NUM_DEC; k++) begin
         pos = {1'b0, ptr} + 5'(k);
         // Fold back into 0..9; the 20 case only covers an out-of-range ptr.
         if (pos >= 5'd20)
            pos = pos - 5'd20;
         else if (pos >= 5'd10)
            pos = pos - 5'd10;
         if (!found && req[pos[3:0]]) begin
            found = 1'b1;
            idx   = pos[3:0];
         end
      end
   end

endmodule

// File: rtl/dec_bcd_arbiter.sv
// Synchronises ten key lines, latches rising edges as pending events and issues them round-robin as BCD.
// Optional drop counter enabled by defining DEC_ARB_DROP_CNT_EN.
module dec_bcd_arbiter
   import dec_bcd_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        dec_req,
   output logic [3:0]        bcd_data,
   output logic              bcd_valid,
   input  logic              bcd_ready,
   output logic [9:0]        pending,
   output logic              busy
`ifdef DEC_ARB_DROP_CNT_EN
   ,output logic [CNT_W-1:0] drop_cnt
`endif
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || CNT_W < 1) begin : g_param_check
      $error("dec_bcd_arbiter: SYNC_STAGES must be 2..3 and CNT_W at least 1");
   end

   logic [SYNC_STAGES-1:0][NUM_DEC-1:0] sync_q, sync_d;
   dec_vec_t   prev_q, prev_d;
   dec_vec_t   pending_q, pending_d;
   logic [3:0] ptr_q, ptr_d;
   logic [3:0] data_q, data_d;
   logic       valid_q, valid_d;

   dec_vec_t   rise;
   dec_vec_t   load_vec;
   logic       slot_free;
   logic       load;
   logic       pick_found;
   logic [3:0] pick_idx;

   dec_rr_pick u_pick (
      .req   (pending_q),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], dec_req};
      prev_d    = sync_q[SYNC_STAGES-1];
      rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
      slot_free = ~valid_q | bcd_ready;
      load      = slot_free & pick_found;
      load_vec  = '0;
      for (int i = 0; i < NUM_DEC; i++)
         load_vec[i] = load && (pick_idx == 4'(i));
      // A fresh edge on the digit being loaded re-arms it rather than being lost.
      pending_d = (pending_q & ~load_vec) | rise;
      valid_d   = slot_free ? pick_found : valid_q;
      data_d    = load ? idx_to_bcd(pick_idx) : data_q;
      ptr_d     = load ? pick_idx : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         ptr_q     <= LAST_IDX;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign bcd_data  = data_q;
   assign bcd_valid = valid_q;
   assign pending   = pending_q;
   assign busy      = valid_q | (|pending_q);

`ifdef DEC_ARB_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   dec_vec_t         drop_vec;
   logic [3:0]       drop_ones;
   logic [CNT_W+3:0] drop_sum;

   always_comb begin
      drop_vec  = rise & pending_q & ~load_vec;
      drop_ones = 4'd0;
      for (int i = 0; i < NUM_DEC; i++)
         drop_ones = drop_ones + {3'b000, drop_vec[i]};
      drop_sum = (CNT_W+4)'(drop_cnt_q) + (CNT_W+4)'(drop_ones);
      if (drop_sum > (CNT_W+4)'({CNT_W{1'b1}}))
         drop_cnt_d = '1;
      else
         drop_cnt_d = drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt_q <= '0;
      else
         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule
